uart_tx_framer: RTL and testbench
=================================

// Module: uart_tx_framer
// PURPOSE
//  Synthesizable serial framer for the far end of the UART rx link; it produces the frames
//  that UART.io_rx decodes. Host bytes are queued in a small FIFO. Each byte is sent on io_tx
//  as: start bit (0), PKT_SIZE data bits MSb first, stop bit (1).
//  Used as an on-chip link partner / loopback source for the UART block and its bench.
// PARAMETERS
//  PKT_SIZE      8  data bits per frame (>=2)
//  CLKS_PER_BIT  3  clock cycles each serial bit is held (>=1)
//  FIFO_DEPTH    4  queued packets; power of two, >=2
// PORTS
//  clock          in   1                          single clock, all state on rising edge
//  reset          in   1                          asynchronous, active-low (0 = reset)
//  io_txReq_pkt   in   PKT_SIZE                   packet to queue
//  io_txReq_req   in   1                          push request, sampled on the clock edge
//  io_txReq_ready out  1                          FIFO not full; push accepted iff req&&ready
//  io_txReq_done  out  1                          1-cycle pulse when a frame's stop bit ends
//  io_tx          out  1                          serial line, idle high
//  io_busy        out  1                          high while state != IDLE
//  io_count       out  $clog2(FIFO_DEPTH)+1       packets waiting in the FIFO (excludes frame in flight)
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - io_tx=1, io_txReq_done=0, io_busy=0, io_count=0, io_txReq_ready=1.
//   - FIFO pointers, bit counter, baud counter and state cleared.
//   - Mid-frame reset aborts the frame: io_tx goes 1 immediately; queued data is discarded.
//  FIFO:
//   - io_txReq_ready = (count != FIFO_DEPTH), from registered count.
//   - Push when full is dropped silently; no state change.
//   - Push and pop in the same cycle: count unchanged.
//   - Pointers wrap modulo FIFO_DEPTH.
//   - No bypass: a push into an empty FIFO is popped no earlier than the next edge.
//  FSM states: IDLE, START, DATA, STOP. io_tx is registered.
//   - IDLE:  io_tx=1. If count>0: pop the head into the shift register, ->START.
//   - START: io_tx=0 for CLKS_PER_BIT cycles, ->DATA.
//   - DATA:  io_tx=shreg[MSb]; shift left every CLKS_PER_BIT cycles; after PKT_SIZE bits ->STOP.
//   - STOP:  io_tx=1 for CLKS_PER_BIT cycles. On the last cycle io_txReq_done=1. Then:
//            if count>0, pop and ->START in the same edge (no idle gap); else ->IDLE.
//  Timing:
//   - Push at edge N into an empty idle block: pop at edge N+1; io_tx=0 from N+1.
//   - Frame length is exactly (PKT_SIZE+2)*CLKS_PER_BIT cycles.
//   - done asserts during the final STOP cycle; it is deasserted on the first cycle of the next START.
//  Baud counter counts 0..CLKS_PER_BIT-1 and reloads on each bit boundary. CLKS_PER_BIT=1 gives one bit per cycle.
//  io_txReq_pkt is captured only on an accepted push; later changes do not affect queued data.
// TESTING (PKT_SIZE=8, CLKS_PER_BIT=3, FIFO_DEPTH=4 unless noted)
//  1. Hold reset=0 for 5 cycles.
//     -> io_tx=1, ready=1, done=0, busy=0, count=0 throughout; io_tx stays 1 for 20 cycles after release.
//  2. Push 0xCD once.
//     -> io_tx bits 0,1,1,0,0,1,1,0,1,1, each held 3 cycles (30 total).
//     -> done is a single pulse in the last stop cycle; then busy=0 and count=0.
//  3. Push 0xAA then 0x55 on consecutive cycles.
//     -> 60 contiguous cycles: 0,10101010,1,0,01010101,1; no idle gap.
//     -> two done pulses exactly 30 cycles apart.
//  4. Push 0x01..0x06 on 6 consecutive cycles.
//     -> count reaches 4 and ready=0 on the 6th push; 0x06 is dropped.
//     -> frames 0x01..0x05 are sent in order; ready returns to 1 when 0x02 is popped.
//  5. Push 0x3C plus 2 more packets, then pull reset low during the 3rd data bit.
//     -> io_tx=1 in the same cycle, count=0, no done.
//     -> after release, io_tx stays 1 for 40 cycles.
//  6. CLKS_PER_BIT=1: push 0x80.
//     -> io_tx = 0,1,0,0,0,0,0,0,0,1 on 10 consecutive cycles; done in the 10th.

Source files
------------

// File: rtl/uart_tx_framer_if.sv
// Host-side push handshake for uart_tx_framer: packet, request, ready and frame-done pulse.
interface uart_tx_framer_if #(
    parameter int unsigned PKT_SIZE = 8
);
    logic [PKT_SIZE-1:0] io_txReq_pkt;
    logic                io_txReq_req;
    logic                io_txReq_ready;
    logic                io_txReq_done;

    modport master (
        output io_txReq_pkt,
        output io_txReq_req,
        input  io_txReq_ready,
        input  io_txReq_done
    );

    modport slave (
        input  io_txReq_pkt,
        input  io_txReq_req,
        output io_txReq_ready,
        output io_txReq_done
    );
endinterface

// File: rtl/uart_tx_framer.sv
// Serial UART framer: queues host bytes in a small FIFO and sends each as
// start(0), PKT_SIZE data bits MSb first, stop(1), every bit held CLKS_PER_BIT cycles.
module uart_tx_framer #(
    parameter int unsigned PKT_SIZE     = 8,
    parameter int unsigned CLKS_PER_BIT = 3,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    uart_tx_framer_if.slave               txreq,
    output logic                          io_tx,
    output logic                          io_busy,
    output logic [$clog2(FIFO_DEPTH):0]   io_count
);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BIT_W  = $clog2(PKT_SIZE);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e              state_q, state_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [PKT_SIZE-1:0] shreg_q, shreg_d;
    logic [PTR_W-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                tx_q, tx_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic                ready_q, ready_d;
    logic [PKT_SIZE-1:0] mem_q [FIFO_DEPTH];

    logic push, pop, last_baud;

    // FIFO storage; pointers are cleared by reset so stale entries are never read.
    always_ff @(posedge clock) begin
        if (push) mem_q[wptr_q] <= txreq.io_txReq_pkt;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
        end
    end

    // tx_d is the line value for the state being entered, so io_tx stays aligned with state_q.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        count_d   = count_q;
        tx_d      = tx_q;
        pop       = 1'b0;
        push      = txreq.io_txReq_req && (count_q != CNT_W'(FIFO_DEPTH));
        last_baud = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = START;
                    baud_d  = '0;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (last_baud) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                    tx_d    = shreg_q[PKT_SIZE-1];
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                    tx_d   = 1'b0;
                end
            end
            DATA: begin
                if (last_baud) begin
                    baud_d = '0;
                    if (bit_q == BIT_W'(PKT_SIZE - 1)) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        shreg_d = shreg_q << 1;
                        bit_d   = bit_q + BIT_W'(1);
                        tx_d    = shreg_q[PKT_SIZE-2];
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (last_baud) begin
                    baud_d = '0;
                    if (count_q != '0) begin
                        // Back-to-back frame: next start bit follows the stop bit directly.
                        pop     = 1'b1;
                        state_d = START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase

        if (pop) begin
            shreg_d = mem_q[rptr_q];
            rptr_d  = rptr_q + PTR_W'(1);
        end
        if (push) wptr_d = wptr_q + PTR_W'(1);

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        done_d  = (state_d == STOP) && (baud_d == BAUD_W'(CLKS_PER_BIT - 1));
        busy_d  = (state_d != IDLE);
        ready_d = (count_d != CNT_W'(FIFO_DEPTH));
    end

    assign io_tx                = tx_q;
    assign io_busy              = busy_q;
    assign io_count             = count_q;
    assign txreq.io_txReq_ready = ready_q;
    assign txreq.io_txReq_done  = done_q;
endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer: table of framed packets plus hand sequences for
// FIFO overflow, mid-frame reset and the one-cycle-per-bit configuration.
module tb_uart_tx_framer;
    logic clock;
    logic reset;
    logic tx3, busy3, tx1, busy1;
    logic [2:0] count3, count1;

    int n_vec = 0;
    int n_bad = 0;

    uart_tx_framer_if #(.PKT_SIZE(8)) if3 ();
    uart_tx_framer_if #(.PKT_SIZE(8)) if1 ();

    uart_tx_framer #(.PKT_SIZE(8), .CLKS_PER_BIT(3), .FIFO_DEPTH(4)) dut3 (
        .clock(clock), .reset(reset), .txreq(if3.slave),
        .io_tx(tx3), .io_busy(busy3), .io_count(count3)
    );

    uart_tx_framer #(.PKT_SIZE(8), .CLKS_PER_BIT(1), .FIFO_DEPTH(4)) dut1 (
        .clock(clock), .reset(reset), .txreq(if1.slave),
        .io_tx(tx1), .io_busy(busy1), .io_count(count1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int         n;
        logic [7:0] p0;
        logic [7:0] p1;
        logic [19:0] exp;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic frame_bit(input logic [7:0] d, input int b);
        logic r;
        if (b == 0)      r = 1'b0;
        else if (b == 9) r = 1'b1;
        else             r = d[8-b];
        return r;
    endfunction

    initial begin
        tbl[0] = '{1, 8'hCD, 8'h00, {10'b0110011011, 10'b0}};
        tbl[1] = '{2, 8'hAA, 8'h55, {10'b0101010101, 10'b0010101011}};
        tbl[2] = '{1, 8'h00, 8'h00, {10'b0000000001, 10'b0}};
        tbl[3] = '{1, 8'hFF, 8'h00, {10'b0111111111, 10'b0}};
        tbl[4] = '{1, 8'hA5, 8'h00, {10'b0101001011, 10'b0}};

        if3.io_txReq_req = 1'b0;
        if3.io_txReq_pkt = 8'h00;
        if1.io_txReq_req = 1'b0;
        if1.io_txReq_pkt = 8'h00;

        // Reset held low for 5 cycles, then line idles high.
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rst_tx", 32'(tx3), 32'd1);
            chk("rst_ready", 32'(if3.io_txReq_ready), 32'd1);
            chk("rst_done", 32'(if3.io_txReq_done), 32'd0);
            chk("rst_busy", 32'(busy3), 32'd0);
            chk("rst_count", 32'(count3), 32'd0);
        end
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_tx", 32'(tx3), 32'd1);
        end

        // Table-driven frames (single and back-to-back).
        for (int v = 0; v < 5; v++) begin
            if3.io_txReq_pkt = tbl[v].p0;
            if3.io_txReq_req = 1'b1;
            tick();
            if (tbl[v].n == 2) if3.io_txReq_pkt = tbl[v].p1;
            else               if3.io_txReq_req = 1'b0;
            for (int i = 0; i < 30 * tbl[v].n; i++) begin
                tick();
                if3.io_txReq_req = 1'b0;
                chk($sformatf("v%0d_tx%0d", v, i), 32'(tx3), 32'(tbl[v].exp[19 - i/3]));
                chk($sformatf("v%0d_done%0d", v, i), 32'(if3.io_txReq_done), 32'((i % 30) == 29));
                if (i == 0) chk($sformatf("v%0d_busy", v), 32'(busy3), 32'd1);
            end
            tick();
            chk($sformatf("v%0d_end_busy", v), 32'(busy3), 32'd0);
            chk($sformatf("v%0d_end_count", v), 32'(count3), 32'd0);
            chk($sformatf("v%0d_end_done", v), 32'(if3.io_txReq_done), 32'd0);
            chk($sformatf("v%0d_end_tx", v), 32'(tx3), 32'd1);
            repeat (3) tick();
        end

        // Overflow: six pushes into a depth-4 FIFO, 0x06 dropped.
        begin
            logic [2:0] exp_cnt [6];
            logic       exp_rdy [6];
            exp_cnt = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
            exp_rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
            for (int j = 0; j < 160; j++) begin
                if (j < 6) begin
                    if3.io_txReq_req = 1'b1;
                    if3.io_txReq_pkt = 8'(j + 1);
                end else begin
                    if3.io_txReq_req = 1'b0;
                    if3.io_txReq_pkt = 8'hEE;
                end
                tick();
                if (j < 6) begin
                    chk($sformatf("ovf_count%0d", j), 32'(count3), 32'(exp_cnt[j]));
                    chk($sformatf("ovf_ready%0d", j), 32'(if3.io_txReq_ready), 32'(exp_rdy[j]));
                end
                if (j == 30) chk("ovf_ready_before_pop2", 32'(if3.io_txReq_ready), 32'd0);
                if (j == 31) begin
                    chk("ovf_ready_after_pop2", 32'(if3.io_txReq_ready), 32'd1);
                    chk("ovf_count_after_pop2", 32'(count3), 32'd3);
                end
                if (j >= 1 && j <= 150) begin
                    int k;
                    logic [7:0] d;
                    k = j - 1;
                    d = 8'(k / 30 + 1);
                    chk($sformatf("ovf_tx%0d", k), 32'(tx3), 32'(frame_bit(d, (k % 30) / 3)));
                    chk($sformatf("ovf_done%0d", k), 32'(if3.io_txReq_done), 32'((k % 30) == 29));
                end
                if (j > 150) begin
                    chk($sformatf("ovf_idle_tx%0d", j), 32'(tx3), 32'd1);
                    chk($sformatf("ovf_idle_busy%0d", j), 32'(busy3), 32'd0);
                end
            end
            chk("ovf_final_count", 32'(count3), 32'd0);
        end

        // Mid-frame reset during the third data bit of 0x3C with two packets queued.
        for (int j = 0; j < 12; j++) begin
            if (j < 3) begin
                if3.io_txReq_req = 1'b1;
                if3.io_txReq_pkt = (j == 0) ? 8'h3C : 8'(8'h70 + j);
            end else begin
                if3.io_txReq_req = 1'b0;
            end
            tick();
        end
        chk("mrst_pre_tx", 32'(tx3), 32'd1);
        chk("mrst_pre_count", 32'(count3), 32'd2);
        #3;
        reset = 1'b0;
        #1;
        chk("mrst_tx", 32'(tx3), 32'd1);
        chk("mrst_count", 32'(count3), 32'd0);
        chk("mrst_done", 32'(if3.io_txReq_done), 32'd0);
        chk("mrst_busy", 32'(busy3), 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            chk($sformatf("mrst_idle_tx%0d", i), 32'(tx3), 32'd1);
            chk($sformatf("mrst_idle_done%0d", i), 32'(if3.io_txReq_done), 32'd0);
        end
        chk("mrst_idle_count", 32'(count3), 32'd0);

        // One clock per bit: 0x80.
        begin
            logic [9:0] exp1;
            exp1 = 10'b0100000001;
            if1.io_txReq_pkt = 8'h80;
            if1.io_txReq_req = 1'b1;
            tick();
            if1.io_txReq_req = 1'b0;
            for (int i = 0; i < 10; i++) begin
                tick();
                chk($sformatf("c1_tx%0d", i), 32'(tx1), 32'(exp1[9 - i]));
                chk($sformatf("c1_done%0d", i), 32'(if1.io_txReq_done), 32'(i == 9));
            end
            tick();
            chk("c1_end_tx", 32'(tx1), 32'd1);
            chk("c1_end_busy", 32'(busy1), 32'd0);
            chk("c1_end_done", 32'(if1.io_txReq_done), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
